// File: rtl/css_mcu0_dmi_reg_bridge.sv
// css_mcu0_dmi_reg_bridge
// Bridges synchronized DMI register accesses (DATA0, DATA1, CMDSTAT,
// COMMAND) to a request/acknowledge command port toward the core.
// Optional feature macro: CSS_MCU0_DMI_BRIDGE_TIMEOUT_EN enables an abort
// counter that ends a WAIT after TIMEOUT_CYCLES cycles without cmd_ack_i.
module css_mcu0_dmi_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_en,
  input  logic        reg_wr_en,
  input  logic [6:0]  reg_wr_addr,
  input  logic [31:0] reg_wr_data,
  output logic [31:0] rd_data,
  output logic        cmd_req_o,
  output logic [31:0] cmd_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ack_i,
  input  logic        cmd_err_i,
  input  logic [31:0] cmd_rdata_i,
  output logic        busy_o
);

  localparam logic [6:0] ADDR_DATA0   = 7'h04;
  localparam logic [6:0] ADDR_DATA1   = 7'h05;
  localparam logic [6:0] ADDR_CMDSTAT = 7'h16;
  localparam logic [6:0] ADDR_COMMAND = 7'h17;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BUSY    = 3'd1;
  localparam logic [2:0] ERR_EXCEPT  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A zero timeout would make the abort counter meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [2:0]  cmderr_q, cmderr_d;

  logic wr_s;
  logic rd_s;
  logic busy_s;
  logic timeout_s;

  assign wr_s   = reg_en & reg_wr_en;
  assign rd_s   = reg_en & ~reg_wr_en;
  assign busy_s = (state_q != ST_IDLE);

`ifdef CSS_MCU0_DMI_BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign timeout_s = (state_q == ST_WAIT) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Count WAIT cycles; the count restarts on every new command.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      tmo_cnt_q <= '0;
    end else if (!timeout_s) begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end else begin
      tmo_cnt_q <= tmo_cnt_q;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Register decode, command FSM and cmderr update; completion events override W1C.
  always_comb begin
    logic start_s;
    logic busy_err_s;
    state_d    = state_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    cmd_d      = cmd_q;
    cmderr_d   = cmderr_q;
    rd_data_d  = rd_data_q;
    start_s    = 1'b0;
    busy_err_s = 1'b0;

    if (rd_s) begin
      case (reg_wr_addr)
        ADDR_DATA0:   rd_data_d = data0_q;
        ADDR_DATA1:   rd_data_d = data1_q;
        ADDR_CMDSTAT: rd_data_d = {19'd0, busy_s, 1'b0, cmderr_q, 8'd0};
        default:      rd_data_d = 32'd0;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end

    if (wr_s) begin
      case (reg_wr_addr)
        ADDR_DATA0: begin
          if (busy_s) busy_err_s = 1'b1;
          else        data0_d    = reg_wr_data;
        end
        ADDR_DATA1: begin
          if (busy_s) busy_err_s = 1'b1;
          else        data1_d    = reg_wr_data;
        end
        ADDR_COMMAND: begin
          if (busy_s) begin
            busy_err_s = 1'b1;
          end else if (cmderr_q == ERR_NONE) begin
            cmd_d   = reg_wr_data;
            start_s = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end
        ADDR_CMDSTAT: cmderr_d = cmderr_q & ~reg_wr_data[10:8];
        default: ;
      endcase
    end else begin
      busy_err_s = 1'b0;
    end

    if (busy_err_s && (cmderr_q == ERR_NONE)) begin
      cmderr_d = ERR_BUSY;
    end else begin
      cmderr_d = cmderr_d;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_WAIT;
        else         state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cmd_ack_i) begin
          state_d = ST_DONE;
          if (cmd_err_i) cmderr_d = ERR_EXCEPT;
          else           data0_d  = cmd_rdata_i;
        end else if (timeout_s) begin
          state_d  = ST_DONE;
          cmderr_d = ERR_TIMEOUT;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register file update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data0_q   <= 32'd0;
      data1_q   <= 32'd0;
      cmd_q     <= 32'd0;
      rd_data_q <= 32'd0;
      cmderr_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      cmd_q     <= cmd_d;
      rd_data_q <= rd_data_d;
      cmderr_q  <= cmderr_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign cmd_req_o  = (state_q == ST_WAIT);
  assign busy_o     = busy_s;
  assign cmd_o      = cmd_q;
  assign cmd_data_o = data0_q;

endmodule

// File: tb/tb_css_mcu0_dmi_reg_bridge.sv
// Directed bench for css_mcu0_dmi_reg_bridge. Read expectations are queued
// by the stimulus and compared by a separate monitor when rd_data updates.
module tb_css_mcu0_dmi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_en = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic [6:0]  reg_wr_addr = 7'd0;
  logic [31:0] reg_wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        cmd_req_o;
  logic [31:0] cmd_o;
  logic [31:0] cmd_data_o;
  logic        cmd_ack_i = 1'b0;
  logic        cmd_err_i = 1'b0;
  logic [31:0] cmd_rdata_i = 32'd0;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic rd_chk = 1'b0;

  css_mcu0_dmi_reg_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .reg_en(reg_en), .reg_wr_en(reg_wr_en),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .rd_data(rd_data),
    .cmd_req_o(cmd_req_o), .cmd_o(cmd_o), .cmd_data_o(cmd_data_o),
    .cmd_ack_i(cmd_ack_i), .cmd_err_i(cmd_err_i), .cmd_rdata_i(cmd_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Remember which edges sampled a read so the monitor knows rd_data is fresh.
  always @(posedge clk) rd_chk <= reg_en && !reg_wr_en && !rst;

  // Monitor: pop and compare one expected read value per serviced read.
  always @(negedge clk) begin
    if (rd_chk) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got %h, no expected value queued", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_en = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    @(negedge clk);
    reg_en = 1'b0; reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, input logic [31:0] e);
    @(negedge clk);
    reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    reg_en = 1'b0;
  endtask

  task automatic ack_pulse(input logic err, input logic [31:0] d);
    @(negedge clk);
    cmd_ack_i = 1'b1; cmd_err_i = err; cmd_rdata_i = d;
    @(negedge clk);
    cmd_ack_i = 1'b0; cmd_err_i = 1'b0;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_hi;
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", {31'd0, cmd_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_cmd_o", cmd_o, 32'd0);
    chk("rst_cmd_data", cmd_data_o, 32'd0);

    // Basic register access
    wr(7'h04, 32'hDEAD_BEEF);
    rd(7'h04, 32'hDEAD_BEEF);
    rd(7'h30, 32'h0000_0000);
    wr(7'h05, 32'hA5A5_0001);
    rd(7'h05, 32'hA5A5_0001);
    wr(7'h30, 32'h1111_1111);
    chk("wr_keeps_rd_data", rd_data, 32'hA5A5_0001);
    rd(7'h17, 32'h0000_0000);
    rd(7'h16, 32'h0000_0000);

    // Successful command, ack after 5 cycles in WAIT
    wr(7'h17, 32'h0022_1000);
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_req_o) n_hi++;
      chk("cmd_o_held", cmd_o, 32'h0022_1000);
      chk("cmd_data_held", cmd_data_o, 32'hDEAD_BEEF);
      if (i == 1) begin
        reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 7'h04;
        exp_q.push_back(32'hDEAD_BEEF);
      end
      if (i == 2) begin
        reg_en = 1'b1; reg_wr_en = 1'b0; reg_wr_addr = 7'h16;
        exp_q.push_back(32'h0000_1000);
      end
      if (i == 4) begin
        cmd_ack_i = 1'b1; cmd_err_i = 1'b0; cmd_rdata_i = 32'h1234_5678;
      end
      @(negedge clk);
      reg_en = 1'b0; cmd_ack_i = 1'b0;
    end
    chk("req_cycles", n_hi, 32'd5);
    chk("req_drop_after_ack", {31'd0, cmd_req_o}, 32'd0);
    chk("busy_in_done", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
    chk("data0_from_core", cmd_data_o, 32'h1234_5678);
    rd(7'h04, 32'h1234_5678);
    rd(7'h16, 32'h0000_0000);

    // Write while busy sets cmderr=1
    wr(7'h17, 32'h0000_0001);
    wr(7'h05, 32'hFFFF_FFFF);
    rd(7'h16, 32'h0000_1100);
    rd(7'h05, 32'hA5A5_0001);
    ack_pulse(1'b0, 32'h1111_2222);
    @(negedge clk);
    chk("busy_idle2", {31'd0, busy_o}, 32'd0);
    rd(7'h04, 32'h1111_2222);
    rd(7'h16, 32'h0000_0100);
    wr(7'h17, 32'h0000_0077);
    chk("cmd_blocked_err1", {31'd0, cmd_req_o}, 32'd0);
    chk("cmd_o_unchanged", cmd_o, 32'h0000_0001);
    wr(7'h16, 32'h0000_0700);
    rd(7'h16, 32'h0000_0000);
    wr(7'h17, 32'h0000_0002);
    chk("cmd_accepted_after_clear", {31'd0, cmd_req_o}, 32'd1);
    chk("cmd_o_second", cmd_o, 32'h0000_0002);

    // Error ack with a simultaneous W1C: hardware set wins
    @(negedge clk);
    cmd_ack_i = 1'b1; cmd_err_i = 1'b1; cmd_rdata_i = 32'hFFFF_0000;
    reg_en = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = 7'h16; reg_wr_data = 32'h0000_0700;
    @(negedge clk);
    cmd_ack_i = 1'b0; cmd_err_i = 1'b0; reg_en = 1'b0; reg_wr_en = 1'b0;
    rd(7'h16, 32'h0000_0300);
    rd(7'h04, 32'h1111_2222);
    wr(7'h17, 32'h0000_0003);
    chk("cmd_blocked_err3", {31'd0, cmd_req_o}, 32'd0);
    @(negedge clk);
    chk("still_idle", {31'd0, busy_o}, 32'd0);
    chk("cmd_o_kept", cmd_o, 32'h0000_0002);

    // Ack in IDLE is ignored
    ack_pulse(1'b1, 32'hDEAD_0000);
    ack_pulse(1'b0, 32'hDEAD_0001);
    rd(7'h16, 32'h0000_0300);
    rd(7'h04, 32'h1111_2222);
    wr(7'h16, 32'h0000_0700);
    rd(7'h16, 32'h0000_0000);

`ifdef CSS_MCU0_DMI_BRIDGE_TIMEOUT_EN
    // Timeout after 16 WAIT cycles, late ack ignored
    wr(7'h17, 32'h0000_0004);
    n_hi = 0;
    guard = 0;
    while (cmd_req_o && guard < 100) begin
      n_hi++;
      guard++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", n_hi, 32'd16);
    chk("timeout_req_low", {31'd0, cmd_req_o}, 32'd0);
    rd(7'h16, 32'h0000_0400);
    ack_pulse(1'b0, 32'h0000_0055);
    rd(7'h04, 32'h1111_2222);
    rd(7'h16, 32'h0000_0400);
    chk("late_ack_req", {31'd0, cmd_req_o}, 32'd0);
    wr(7'h16, 32'h0000_0700);
`else
    // Without the timeout the request persists until acknowledged
    wr(7'h17, 32'h0000_0004);
    repeat (40) @(negedge clk);
    chk("wait_persists", {31'd0, cmd_req_o}, 32'd1);
    ack_pulse(1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    rd(7'h04, 32'hCAFE_F00D);
    rd(7'h16, 32'h0000_0000);
`endif

    // Reset in WAIT abandons the command
    wr(7'h17, 32'h0000_0009);
    chk("req_before_rst", {31'd0, cmd_req_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_req", {31'd0, cmd_req_o}, 32'd0);
    chk("rst_wait_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_wait_cmd_o", cmd_o, 32'd0);
    chk("rst_wait_cmd_data", cmd_data_o, 32'd0);
    chk("rst_wait_rd_data", rd_data, 32'd0);
    rd(7'h04, 32'd0);
    rd(7'h05, 32'd0);
    rd(7'h16, 32'd0);
    rd(7'h17, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
